// File: rtl/spi_frame_slave.sv
// rtl/spi_frame_slave.sv - SPI-style frame receiver publishing {mode, loc, addr, key} on ss release
// Parametrised key loader front end with per-clk or sclk-strobed sampling.
module spi_frame_slave #(
    parameter int KEY_W       = 128,
    parameter int ADDR_W      = 8,
    parameter int LOC_W       = 8,
    parameter int SAMPLE_MODE = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ss,
    input  logic              sclk,
    input  logic              mosi,
    output logic              mode,
    output logic [LOC_W-1:0]  usr_loc,
    output logic [ADDR_W-1:0] usr_addr,
    output logic [KEY_W-1:0]  usr_key,
    output logic              start,
    output logic              frame_err,
    output logic              busy
);

    localparam int FRAME_W = 1 + LOC_W + ADDR_W + KEY_W;
    localparam int CNT_W   = $clog2(FRAME_W + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FRAME_W);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        OVER  = 2'd2
    } state_t;

    state_t               state_q;
    logic [FRAME_W-1:0]   sr_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 ss_q;
    logic                 sclk_prev_q;
    logic [SYNC_STAGES-1:0] ss_sync_q;
    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;

    logic ss_i;
    logic sclk_i;
    logic mosi_i;
    logic strobe;
    logic ss_rise;

    // The synchroniser chains fold away when SAMPLE_MODE=0 selects the raw pins.
    assign ss_i   = (SAMPLE_MODE != 0) ? ss_sync_q[SYNC_STAGES-1]   : ss;
    assign sclk_i = (SAMPLE_MODE != 0) ? sclk_sync_q[SYNC_STAGES-1] : sclk;
    assign mosi_i = (SAMPLE_MODE != 0) ? mosi_sync_q[SYNC_STAGES-1] : mosi;

    assign strobe  = (SAMPLE_MODE != 0) ? (sclk_i & ~sclk_prev_q) : ~ss_i;
    assign ss_rise = ss_i & ~ss_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            sr_q        <= '0;
            cnt_q       <= '0;
            ss_q        <= 1'b0;
            sclk_prev_q <= 1'b0;
            ss_sync_q   <= '0;
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            mode        <= 1'b0;
            usr_loc     <= '0;
            usr_addr    <= '0;
            usr_key     <= '0;
            start       <= 1'b0;
            frame_err   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], ss};
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
            ss_q        <= ss_i;
            sclk_prev_q <= sclk_i;
            start       <= 1'b0;
            frame_err   <= 1'b0;

            case (state_q)
                IDLE: begin
                    // ss_q resets low, so ss held low through reset never looks like a falling edge.
                    if (ss_q && !ss_i) begin
                        state_q <= SHIFT;
                        busy    <= 1'b1;
                        if (SAMPLE_MODE == 0) begin
                            sr_q  <= FRAME_W'(mosi_i);
                            cnt_q <= CNT_W'(1);
                        end else begin
                            sr_q  <= '0;
                            cnt_q <= '0;
                        end
                    end
                end
                SHIFT: begin
                    if (ss_rise) begin
                        if (cnt_q == FULL_CNT) begin
                            mode     <= sr_q[FRAME_W-1];
                            usr_loc  <= sr_q[FRAME_W-2 -: LOC_W];
                            usr_addr <= sr_q[KEY_W+ADDR_W-1 -: ADDR_W];
                            usr_key  <= sr_q[KEY_W-1:0];
                            start    <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                        state_q <= IDLE;
                        busy    <= 1'b0;
                    end else if (strobe) begin
                        if (cnt_q == FULL_CNT) begin
                            state_q <= OVER;
                        end else begin
                            sr_q  <= {sr_q[FRAME_W-2:0], mosi_i};
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                OVER: begin
                    if (ss_rise) begin
                        frame_err <= 1'b1;
                        state_q   <= IDLE;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
